// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory and
// presents the PC/Instruction pair for IF/ID, honouring ID freeze and EXE redirects.
module if_fetch_unit #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               freeze_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               valid_o
);

    localparam logic [0:0] StReq  = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0]  bufpc_q, bufpc_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
    logic [INSTR_W-1:0] last_instr_q, last_instr_d;

    logic [ADDR_W-1:0]  br_addr;
    logic [ADDR_W-1:0]  pc_inc;

    assign br_addr     = branch_addr_i & AlignMask;
    assign pc_inc      = pc_q + ADDR_W'(4);
    assign imem_addr_o = pc_q & AlignMask;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        bufpc_d       = bufpc_q;
        pend_d        = pend_q;
        tgt_d         = tgt_q;
        imem_req_o    = 1'b0;
        valid_o       = 1'b0;
        pc_o          = last_pc_q;
        instruction_o = last_instr_q;

        if (rst_ni) begin
            case (state_q)
                StReq: begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        if (branch_taken_i || pend_q) begin
                            // In-flight word is wrong-path; a live branch beats a pending one.
                            pc_d   = branch_taken_i ? br_addr : tgt_q;
                            pend_d = 1'b0;
                        end else if (freeze_i) begin
                            buf_d   = imem_rdata_i;
                            bufpc_d = pc_inc;
                            state_d = StHold;
                        end else begin
                            valid_o       = 1'b1;
                            pc_o          = pc_inc;
                            instruction_o = imem_rdata_i;
                            pc_d          = pc_inc;
                        end
                    end else if (branch_taken_i) begin
                        pend_d = 1'b1;
                        tgt_d  = br_addr;
                    end
                end
                StHold: begin
                    if (branch_taken_i) begin
                        pc_d    = br_addr;
                        state_d = StReq;
                    end else if (!freeze_i) begin
                        valid_o       = 1'b1;
                        pc_o          = bufpc_q;
                        instruction_o = buf_q;
                        pc_d          = bufpc_q;
                        state_d       = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end else begin
            pc_o          = '0;
            instruction_o = '0;
        end

        last_pc_d    = valid_o ? pc_o : last_pc_q;
        last_instr_d = valid_o ? instruction_o : last_instr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            bufpc_q      <= '0;
            pend_q       <= 1'b0;
            tgt_q        <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            bufpc_q      <= bufpc_d;
            pend_q       <= pend_d;
            tgt_q        <= tgt_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: directed scenarios then random freeze/branch/
// wait-state traffic, checked cycle by cycle against a word-availability model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .freeze_i      (freeze),
        .branch_taken_i(br),
        .branch_addr_i (baddr),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .pc_o          (pc),
        .instruction_o (instr),
        .valid_o       (valid)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model: which word is wanted next, whether a fetched word is waiting, and whether
    // the read in flight belongs to a path a branch has already abandoned.
    bit          m_have_word;
    bit          m_wrong_path;
    logic [31:0] m_fetch;
    logic [31:0] m_word;
    logic [31:0] m_target;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit f, input bit b, input logic [31:0] ba,
                         input bit a);
        exp_t        e;
        logic [31:0] dpc;
        @(posedge clk);
        #1;
        rst_n  = r;
        freeze = f;
        br     = b;
        baddr  = ba;
        ack    = a;
        rdata  = a ? mem_word(addr) : $urandom;

        e.req   = 1'b0;
        e.addr  = m_fetch;
        e.valid = 1'b0;
        if (!r) begin
            e.pc           = 32'h0;
            e.instr        = 32'h0;
            m_have_word    = 1'b0;
            m_wrong_path   = 1'b0;
            m_fetch        = 32'h0;
            m_last_pc      = 32'h0;
            m_last_instr   = 32'h0;
        end else begin
            e.req = !m_have_word;
            if (b) begin
                // Anything not yet delivered is dropped; an un-acked read must still finish.
                m_target = ba & 32'hFFFF_FFFC;
                if (m_have_word || a) begin
                    m_fetch      = m_target;
                    m_have_word  = 1'b0;
                    m_wrong_path = 1'b0;
                end else begin
                    m_wrong_path = 1'b1;
                end
            end else if (!m_have_word && a && m_wrong_path) begin
                m_fetch      = m_target;
                m_wrong_path = 1'b0;
            end else if (m_have_word || a) begin
                if (!m_have_word) m_word = mem_word(m_fetch);
                if (f) begin
                    m_have_word = 1'b1;
                end else begin
                    dpc          = m_fetch + 32'd4;
                    e.valid      = 1'b1;
                    m_last_pc    = dpc;
                    m_last_instr = m_word;
                    m_fetch      = dpc;
                    m_have_word  = 1'b0;
                end
            end
            e.pc    = m_last_pc;
            e.instr = m_last_instr;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imem_req", {31'b0, req}, {31'b0, e.req});
            if (e.req) chk("imem_addr", addr, e.addr);
            chk("valid", {31'b0, valid}, {31'b0, e.valid});
            chk("pc", pc, e.pc);
            chk("instruction", instr, e.instr);
        end
    end

    initial begin
        bit          f;
        bit          b;
        bit          a;
        logic [31:0] ba;
        rst_n  = 1'b0;
        freeze = 1'b0;
        br     = 1'b0;
        baddr  = 32'h0;
        ack    = 1'b0;
        rdata  = 32'h0;
        m_have_word  = 1'b0;
        m_wrong_path = 1'b0;
        m_fetch      = 32'h0;
        m_word       = 32'h0;
        m_target     = 32'h0;
        m_last_pc    = 32'h0;
        m_last_instr = 32'h0;

        // Zero-wait stream from reset.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 1);
        // Redirect to 0x10, then two wait states.
        cycle(1, 0, 1, 32'h10, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        // Freeze three cycles on the ack of 0x20, then release.
        cycle(1, 0, 1, 32'h20, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        // Branch during a wait state; stale data discarded; then branch+freeze on ack.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h100, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 1, 32'h103, 1);
        cycle(1, 0, 0, 0, 1);
        // Reset mid-wait at 0x40 with a late ack while held in reset.
        cycle(1, 0, 1, 32'h40, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        // PC wraps from the top of the address space.
        cycle(1, 0, 1, 32'hFFFF_FFFC, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 2) != 0) && !m_have_word;
            case ($urandom_range(0, 3))
                0:       ba = 32'hFFFF_FFF8;
                1:       ba = $urandom & 32'h0000_0FFF;
                2:       ba = 32'hFFFF_FFFF;
                default: ba = $urandom;
            endcase
            if ($urandom_range(0, 99) == 0) cycle(0, f, b, ba, $urandom_range(0, 1) == 1);
            else cycle(1, f, b, ba, a);
        end

        cycle(1, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
